// File: rtl/minisrc_ctrl_pkg.sv
// miniSRC control unit shared definitions: opcodes, ctl bit map, FSM state encoding.
package minisrc_ctrl_pkg;

  localparam int unsigned STEP_W = 4;
  localparam int unsigned OP_W   = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b10101;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // ctl bit indices
  localparam int unsigned CTL_PCOUT     = 0;
  localparam int unsigned CTL_MARIN     = 1;
  localparam int unsigned CTL_INCPC     = 2;
  localparam int unsigned CTL_PC_EN     = 3;
  localparam int unsigned CTL_MEMREAD   = 4;
  localparam int unsigned CTL_MEMWRITE  = 5;
  localparam int unsigned CTL_MDRIN     = 6;
  localparam int unsigned CTL_MDROUT    = 7;
  localparam int unsigned CTL_IR_EN     = 8;
  localparam int unsigned CTL_GRA       = 9;
  localparam int unsigned CTL_GRB       = 10;
  localparam int unsigned CTL_GRC       = 11;
  localparam int unsigned CTL_RIN       = 12;
  localparam int unsigned CTL_ROUT      = 13;
  localparam int unsigned CTL_BAOUT     = 14;
  localparam int unsigned CTL_YIN       = 15;
  localparam int unsigned CTL_ZIN       = 16;
  localparam int unsigned CTL_ZLOWOUT   = 17;
  localparam int unsigned CTL_ZHIGHOUT  = 18;
  localparam int unsigned CTL_LOIN      = 19;
  localparam int unsigned CTL_HIIN      = 20;
  localparam int unsigned CTL_COUT      = 21;
  localparam int unsigned CTL_CONIN     = 22;
  localparam int unsigned CTL_INPORTOUT = 23;
  localparam int unsigned CTL_OUTPORT_EN = 24;
  localparam int unsigned CTL_HIOUT     = 25;
  localparam int unsigned CTL_LOOUT     = 26;
  localparam int unsigned CTL_W         = 27;

  // FSM state encoding; T0..T3 double as fetch step numbers 0..3
  localparam logic [2:0] ST_T0   = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_EXEC = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  // jal is reserved and everything above halt is unassigned
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_HALT) && (op != OP_JAL);
  endfunction

endpackage

// File: rtl/minisrc_step_decode.sv
// Pure combinational control-step decode: (opcode, step, conff) -> (ctl, alu_op, last_step).
// Steps 0..3 are the fetch sequence, 4 and up are execute steps.
module minisrc_step_decode
  import minisrc_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W = 4
) (
  input  logic [OP_W-1:0]   opcode,
  input  logic [STEP_W-1:0] step,
  input  logic              conff,
  output logic [CTL_W-1:0]  ctl,
  output logic [OP_W-1:0]   alu_op,
  output logic              last_step
);

  int unsigned s_c;
  logic        imm_c;

  assign s_c   = 32'(step);
  assign imm_c = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);

  // Per-step control word; unknown or out-of-range steps terminate the instruction
  always_comb begin
    ctl       = '0;
    alu_op    = '0;
    last_step = 1'b0;
    if (s_c < 4) begin
      case (s_c)
        0: begin
          ctl[CTL_PCOUT] = 1'b1; ctl[CTL_MARIN] = 1'b1;
          ctl[CTL_INCPC] = 1'b1; ctl[CTL_PC_EN] = 1'b1;
        end
        1: ctl[CTL_MEMREAD] = 1'b1;
        2: begin ctl[CTL_MEMREAD] = 1'b1; ctl[CTL_MDRIN] = 1'b1; end
        default: begin ctl[CTL_MDROUT] = 1'b1; ctl[CTL_IR_EN] = 1'b1; end
      endcase
    end else begin
      case (opcode)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
        OP_ADDI, OP_ANDI, OP_ORI: begin
          alu_op = opcode;
          case (s_c)
            4: begin ctl[CTL_GRB] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_YIN] = 1'b1; end
            5: begin
              ctl[CTL_ZIN] = 1'b1;
              if (imm_c) ctl[CTL_COUT] = 1'b1;
              else begin ctl[CTL_GRC] = 1'b1; ctl[CTL_ROUT] = 1'b1; end
            end
            6: begin
              ctl[CTL_ZLOWOUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
              last_step = 1'b1;
            end
            default: last_step = 1'b1;
          endcase
        end
        OP_MUL, OP_DIV: begin
          alu_op = opcode;
          case (s_c)
            4: begin ctl[CTL_GRB] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_YIN] = 1'b1; end
            5: begin ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_ZIN] = 1'b1; end
            6: begin ctl[CTL_ZLOWOUT] = 1'b1; ctl[CTL_LOIN] = 1'b1; end
            7: begin ctl[CTL_ZHIGHOUT] = 1'b1; ctl[CTL_HIIN] = 1'b1; last_step = 1'b1; end
            default: last_step = 1'b1;
          endcase
        end
        OP_NEG, OP_NOT: begin
          alu_op = opcode;
          case (s_c)
            4: begin ctl[CTL_GRB] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_ZIN] = 1'b1; end
            5: begin
              ctl[CTL_ZLOWOUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
              last_step = 1'b1;
            end
            default: last_step = 1'b1;
          endcase
        end
        OP_LD, OP_LDI, OP_ST: begin
          case (s_c)
            4: begin ctl[CTL_GRB] = 1'b1; ctl[CTL_BAOUT] = 1'b1; ctl[CTL_YIN] = 1'b1; end
            5: begin ctl[CTL_COUT] = 1'b1; ctl[CTL_ZIN] = 1'b1; alu_op = OP_ADD; end
            6: begin
              ctl[CTL_ZLOWOUT] = 1'b1;
              if (opcode == OP_LDI) begin
                ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1; last_step = 1'b1;
              end else begin
                ctl[CTL_MARIN] = 1'b1;
              end
            end
            7: begin
              if (opcode == OP_ST) begin
                ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_MDRIN] = 1'b1;
              end else begin
                ctl[CTL_MEMREAD] = 1'b1;
              end
            end
            8: begin
              if (opcode == OP_ST) begin
                ctl[CTL_MEMWRITE] = 1'b1; last_step = 1'b1;
              end else begin
                ctl[CTL_MEMREAD] = 1'b1; ctl[CTL_MDRIN] = 1'b1;
              end
            end
            9: begin
              ctl[CTL_MDROUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
              last_step = 1'b1;
            end
            default: last_step = 1'b1;
          endcase
        end
        OP_BR: begin
          case (s_c)
            4: begin ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_CONIN] = 1'b1; end
            5: begin ctl[CTL_PCOUT] = 1'b1; ctl[CTL_YIN] = 1'b1; end
            6: begin ctl[CTL_COUT] = 1'b1; ctl[CTL_ZIN] = 1'b1; alu_op = OP_ADD; end
            7: begin
              ctl[CTL_ZLOWOUT] = 1'b1; ctl[CTL_PC_EN] = conff; last_step = 1'b1;
            end
            default: last_step = 1'b1;
          endcase
        end
        OP_JR: begin
          ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_PC_EN] = 1'b1;
          last_step = 1'b1;
        end
        OP_IN: begin
          ctl[CTL_INPORTOUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
          last_step = 1'b1;
        end
        OP_OUT: begin
          ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_OUTPORT_EN] = 1'b1;
          last_step = 1'b1;
        end
        OP_MFHI: begin
          ctl[CTL_HIOUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
          last_step = 1'b1;
        end
        OP_MFLO: begin
          ctl[CTL_LOOUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
          last_step = 1'b1;
        end
        default: last_step = 1'b1;  // nop, halt, jal and undefined opcodes
      endcase
    end
  end

endmodule

// File: rtl/minisrc_control_unit.sv
// miniSRC hardwired control unit: fetch/decode/execute FSM, step counter, halt and illegal tracking.
// Optional build macro SINGLE_STEP_EN adds step_en/step inputs that gate each instruction at T0.
module minisrc_control_unit
  import minisrc_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             conff,
  input  logic             stop,
`ifdef SINGLE_STEP_EN
  input  logic             step_en,
  input  logic             step,
`endif
  output logic [CTL_W-1:0] ctl,
  output logic [OP_W-1:0]  alu_op,
  output logic             run,
  output logic             illegal
);

  logic [2:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              started_q, started_d;
  logic              run_q, run_d;
  logic              illegal_q, illegal_d;

  logic [OP_W-1:0]   opcode;
  logic              ir_unused;
  logic              hold_c;
  logic              active_c;
  logic [STEP_W-1:0] cur_step_c;
  logic [CTL_W-1:0]  dec_ctl;
  logic [OP_W-1:0]   dec_alu;
  logic              dec_last;

  assign opcode    = ir[31:27];
  assign ir_unused = ^ir[26:0];

`ifdef SINGLE_STEP_EN
  assign hold_c = (state_q == ST_T0) && step_en && !step;
`else
  assign hold_c = 1'b0;
`endif

  // Fetch states map straight onto steps 0..3; execute uses the step counter
  assign cur_step_c = (state_q == ST_EXEC) ? step_q : STEP_W'(state_q);
  assign active_c   = started_q && !hold_c && (state_q != ST_HALT);

  minisrc_step_decode #(.STEP_W(STEP_W)) u_dec (
    .opcode    (opcode),
    .step      (cur_step_c),
    .conff     (conff),
    .ctl       (dec_ctl),
    .alu_op    (dec_alu),
    .last_step (dec_last)
  );

  assign ctl     = active_c ? dec_ctl : '0;
  assign alu_op  = active_c ? dec_alu : '0;
  assign run     = run_q;
  assign illegal = illegal_q;

  // Next-state: the first clock after reset only arms the sequencer so T0 follows it
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    started_d = started_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_T0: begin
        if (!started_q)   started_d = 1'b1;
        else if (!hold_c) state_d   = ST_T1;
      end
      ST_T1: state_d = ST_T2;
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        state_d = ST_EXEC;
        step_d  = STEP_W'(4);
      end
      ST_EXEC: begin
        if ((step_q == STEP_W'(4)) && !op_is_legal(opcode)) illegal_d = 1'b1;
        if (dec_last) begin
          step_d  = '0;
          state_d = (stop || (opcode == OP_HALT)) ? ST_HALT : ST_T0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase
    run_d = started_d && (state_d != ST_HALT);
  end

  // State, step counter and status flops
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_T0;
      step_q    <= '0;
      started_q <= 1'b0;
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      started_q <= started_d;
      run_q     <= run_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
